// File: rtl/gray_cnt_rx_checker.sv
// Receive-side monitor for a gray-coded count stream: converts each valid sample to binary,
// checks it against previous+1, pulses step-error/wrap, and keeps a saturating error count.
//
// state      | meaning
// S_UNLOCKED | no reference sample held yet; next valid sample becomes the reference
// S_LOCKED   | reference held; every valid sample is step-checked and becomes the new reference
module gray_cnt_rx_checker #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_gray_vld,
    input  logic [WIDTH-1:0] i_gray_cnt,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_bin_cnt,
    output logic             o_bin_vld,
    output logic             o_locked,
    output logic             o_step_err,
    output logic             o_wrap,
    output logic [ERR_W-1:0] o_err_cnt
);

    typedef enum logic {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] prev_bin_q;
    logic [WIDTH-1:0] exp_bin;
    logic             step_ok;
    logic             step_err_d;
    logic             bin_vld_q;
    logic             locked_q;
    logic             step_err_q;
    logic             wrap_q;
    logic [ERR_W-1:0] err_cnt_q;

    // Each binary bit is the XOR of the gray bits at and above it.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_d[i] = ^(i_gray_cnt >> i);
        end
    end

    assign exp_bin    = prev_bin_q + 1'b1;
    assign step_ok    = (bin_d == exp_bin);
    assign step_err_d = i_gray_vld && (state_q == S_LOCKED) && !step_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_UNLOCKED;
            prev_bin_q <= '0;
            bin_vld_q  <= 1'b0;
            locked_q   <= 1'b0;
            step_err_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            bin_vld_q  <= 1'b0;
            step_err_q <= 1'b0;
            wrap_q     <= 1'b0;

            // The reference always resyncs to the new sample so one bad sample costs at most two errors.
            if (i_gray_vld) begin
                prev_bin_q <= bin_d;
                bin_vld_q  <= 1'b1;
                state_q    <= S_LOCKED;
                locked_q   <= 1'b1;
                if (state_q == S_LOCKED) begin
                    step_err_q <= !step_ok;
                    wrap_q     <= step_ok && (&prev_bin_q);
                end
            end

            if (i_err_clr) begin
                err_cnt_q <= '0;
            end else if (step_err_d && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign o_bin_cnt  = prev_bin_q;
    assign o_bin_vld  = bin_vld_q;
    assign o_locked   = locked_q;
    assign o_step_err = step_err_q;
    assign o_wrap     = wrap_q;
    assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_cnt_rx_checker.sv
// Self-checking bench for gray_cnt_rx_checker: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of the stream rules.
module tb_gray_cnt_rx_checker;

    localparam int WIDTH = 4;
    localparam int ERR_W = 8;
    localparam int MODN  = 1 << WIDTH;
    localparam int EMAX  = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             i_gray_vld;
    logic [WIDTH-1:0] i_gray_cnt;
    logic             i_err_clr;
    logic [WIDTH-1:0] o_bin_cnt;
    logic             o_bin_vld;
    logic             o_locked;
    logic             o_step_err;
    logic             o_wrap;
    logic [ERR_W-1:0] o_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit m_locked;
    int m_prev;
    int m_err;
    bit m_vld, m_step, m_wrap;

    gray_cnt_rx_checker #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_gray_vld (i_gray_vld),
        .i_gray_cnt (i_gray_cnt),
        .i_err_clr  (i_err_clr),
        .o_bin_cnt  (o_bin_cnt),
        .o_bin_vld  (o_bin_vld),
        .o_locked   (o_locked),
        .o_step_err (o_step_err),
        .o_wrap     (o_wrap),
        .o_err_cnt  (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_gray(int b);
        return (b ^ (b >> 1)) % MODN;
    endfunction

    // Gray to binary by repeated prefix XOR of shifted copies.
    function automatic int from_gray(int g);
        int b = 0;
        for (int s = 0; s < WIDTH; s++) b = b ^ (g >> s);
        return b % MODN;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_prev = 0; m_err = 0;
        m_vld = 0; m_step = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit vld, input int g, input bit clr);
        int b;
        bit inc = 0;
        m_vld = 0; m_step = 0; m_wrap = 0;
        if (vld) begin
            b = from_gray(g);
            m_vld = 1;
            if (m_locked) begin
                if (b == (m_prev + 1) % MODN) m_wrap = (m_prev == MODN - 1) && (b == 0);
                else begin m_step = 1; inc = 1; end
            end
            m_locked = 1;
            m_prev = b;
        end
        if (clr) m_err = 0;
        else if (inc && m_err < EMAX) m_err = m_err + 1;
    endtask

    task automatic compare_all();
        check("bin_cnt",  int'(o_bin_cnt),  m_prev);
        check("bin_vld",  int'(o_bin_vld),  int'(m_vld));
        check("locked",   int'(o_locked),   int'(m_locked));
        check("step_err", int'(o_step_err), int'(m_step));
        check("wrap",     int'(o_wrap),     int'(m_wrap));
        check("err_cnt",  int'(o_err_cnt),  m_err);
    endtask

    // Apply one cycle of inputs, then check outputs 1 ns after the edge.
    task automatic cyc(input bit vld, input int g, input bit clr);
        i_gray_vld = vld;
        i_gray_cnt = WIDTH'(g);
        i_err_clr  = clr;
        @(posedge clk);
        #1;
        model_step(vld, g, clr);
        compare_all();
    endtask

    task automatic send_bin(input int b);
        cyc(1'b1, to_gray(b), 1'b0);
    endtask

    initial begin
        int b;
        i_gray_vld = 0; i_gray_cnt = '0; i_err_clr = 0;
        rst_n = 0;
        model_reset();
        #2000;
        check("reset_locked", int'(o_locked), 0);
        check("reset_err", int'(o_err_cnt), 0);
        compare_all();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // legal stream 0..15 then wrap to 0
        for (int k = 0; k < MODN; k++) begin
            send_bin(k);
            if (k == 0) check("first_locked_lit", int'(o_locked), 1);
        end
        check("bin15_lit", int'(o_bin_cnt), 15);
        send_bin(0);
        check("wrap_lit", int'(o_wrap), 1);
        check("wrap_bin_lit", int'(o_bin_cnt), 0);
        check("wrap_noerr_lit", int'(o_step_err), 0);
        cyc(0, 0, 0);
        check("wrap_one_cycle_lit", int'(o_wrap), 0);
        check("stream_err_lit", int'(o_err_cnt), 0);

        // skip: 1,2 legal, then 4 (error), 5 legal
        send_bin(1);
        send_bin(2);
        cyc(1, 4'b0110, 0);
        check("skip_step_lit", int'(o_step_err), 1);
        check("skip_err_lit", int'(o_err_cnt), 1);
        cyc(1, 4'b0111, 0);
        check("resync_lit", int'(o_step_err), 0);

        // repeated sample with idle gaps
        cyc(1, 4'b0010, 0);
        cyc(0, 0, 0);
        check("idle_nopulse_lit", int'(o_bin_vld), 0);
        cyc(1, 4'b0010, 0);
        check("repeat_step_lit", int'(o_step_err), 1);
        check("repeat_err_lit", int'(o_err_cnt), 3);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            bit v = ($urandom_range(0, 3) != 0);
            bit c = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 9) < 8) b = (m_prev + 1) % MODN;
            else b = $urandom_range(0, MODN - 1);
            cyc(v, to_gray(b), c);
        end

        // saturation: 300 repeats of one value
        cyc(0, 0, 1);
        for (int k = 0; k < 300; k++) cyc(1, 4'b0101, 0);
        check("sat_lit", int'(o_err_cnt), 255);
        cyc(1, 4'b0101, 1);
        check("clr_vs_err_lit", int'(o_err_cnt), 0);
        check("clr_step_pulse_lit", int'(o_step_err), 1);

        // asynchronous reset mid-stream
        send_bin((m_prev + 1) % MODN);
        send_bin((m_prev + 1) % MODN);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check("async_locked_lit", int'(o_locked), 0);
        check("async_vld_lit", int'(o_bin_vld), 0);
        compare_all();
        i_gray_vld = 1; i_gray_cnt = 4'b0011;
        #50;
        compare_all();
        rst_n = 1;
        i_gray_vld = 0;
        @(negedge clk);
        cyc(1, 4'b1100, 0);
        check("relock_bin_lit", int'(o_bin_cnt), 8);
        check("relock_noerr_lit", int'(o_step_err), 0);
        check("relock_locked_lit", int'(o_locked), 1);
        send_bin(9);
        send_bin(3);
        cyc(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
